adjust_tick_generator: RTL and testbench
========================================

# adjust_tick_generator

Front-end for manual time and date setting in the clock/calendar. Converts three raw push-buttons (mode, up, down) into per-field single-cycle `tick_up`/`tick_down` pulses for the field counters. It synchronises and debounces the buttons, cycles the field being edited, and auto-repeats while a button is held. It sits between the board buttons and the seconds/minutes/hours/day/month/year counter bank.

## Interface
- `DEBOUNCE_CYCLES`, 20: consecutive stable cycles before a debounced level changes; ≥1.
- `REPEAT_DELAY`, 500: cycles from first tick to first auto-repeat tick; ≥ `REPEAT_PERIOD`.
- `REPEAT_PERIOD`, 100: cycles between auto-repeat ticks; ≥2.
- `NUM_FIELDS`, 6: number of adjustable fields.
- `FIELD_BITS`, 3: width of `field_sel`; 2^FIELD_BITS ≥ NUM_FIELDS.

- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `btn_mode` in 1: raw mode button, active-high, asynchronous to `clk`.
- `btn_up` in 1: raw up button, active-high, async.
- `btn_down` in 1: raw down button, active-high, async.
- `adjust_en` out 1: high while a field is selected for editing.
- `field_sel` out FIELD_BITS: index of the field being edited; 0 when not adjusting.
- `tick_up` out NUM_FIELDS: one-hot, single-cycle increment pulse to the selected field.
- `tick_down` out NUM_FIELDS: one-hot, single-cycle decrement pulse to the selected field.

## Operation
- **Reset.** All outputs are 0, debounced levels are 0, the mode is IDLE, and the repeat FSM is R_IDLE.
- **Input path.** Each button goes through a 2-FF synchroniser, then a debouncer.
  - The debouncer counter increments while the synchronised level differs from the debounced level, and clears when they match.
  - At `DEBOUNCE_CYCLES` the debounced level flips and the counter clears.
- **Mode.** Each debounced rising edge of mode advances IDLE → field 0 → … → field NUM_FIELDS-1 → IDLE.
  - `adjust_en` is 1 in every state except IDLE.
- **Repeat FSM.** States are R_IDLE, R_DELAY, R_REPEAT and R_LOCK. "Up" and "down" below mean the debounced levels.
  - **R_IDLE → R_DELAY.** Taken on a rising edge of up or down while `adjust_en`=1 and the other button is low. Emits one tick for that direction at `field_sel` and loads the timer with `REPEAT_DELAY`.
  - **R_DELAY → R_REPEAT.** When the timer expires with the button still held, emits a tick and reloads the timer with `REPEAT_PERIOD`.
  - **R_REPEAT.** Emits a tick on each expiry while the button is held.
  - **Release.** In R_DELAY or R_REPEAT, releasing the active button returns to R_IDLE with no tick.
  - **Entry to R_LOCK.** From any non-idle state, any of these moves to R_LOCK with no tick:
    - up and down both high;
    - a mode rising edge;
    - `adjust_en` falling.
  - **R_LOCK → R_IDLE.** Only when up and down are both low. A new tick requires a fresh press.
- **Simultaneous rising edges** of up and down in R_IDLE produce no tick and go to R_LOCK.
- **Up/down while `adjust_en`=0** produces no tick.
- **Tick outputs** are registered. At most one bit of `tick_up | tick_down` is high in any cycle. Consecutive ticks are separated by at least one low cycle, which suits the edge-triggered counters.

## Timing
- **Press latency.** Raw button stable high before edge E0 gives debounced high after edge E(1+DEBOUNCE_CYCLES) and tick high after edge E(2+DEBOUNCE_CYCLES), for exactly one cycle.
- **Auto-repeat.** The second tick rises REPEAT_DELAY cycles after the first. Subsequent ticks rise every REPEAT_PERIOD cycles.
- **Mode latency.** `field_sel`/`adjust_en` update one cycle after the debounced mode edge, the same latency as a tick.
- **Glitches.** Any glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles has no effect.
- **Reset mid-operation.** Outputs clear immediately on `rst`. After release the block behaves as from power-up; a button still held must not tick until released and pressed again.

## Structure
- **Package `clock_adjust_pkg`** holds:
  - the repeat FSM state enum;
  - field index constants FIELD_SEC=0, FIELD_MIN=1, FIELD_HOUR=2, FIELD_DAY=3, FIELD_MONTH=4, FIELD_YEAR=5.
- **Sub-module `button_debouncer`** contains the synchroniser, the debouncer and a registered rising-edge output. It is instantiated three times.
- The top level holds the mode register, the repeat FSM, the timer and the tick decoder.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
1. Three mode presses, then `btn_up` held for 8 cycles → exactly one `tick_up`=6'b000100, 6 cycles after the first sampling edge of up.
2. Field 0 with up held 30 cycles from its first tick at t0 → ticks at t0, t0+10, t0+13, t0+16 … t0+28; none after release.
3. Field 1 with `btn_down` toggling every 2 cycles for 20 cycles, then steady low → no `tick_down`, `field_sel` stays 1.
4. Field 3 with up held; down pressed at t0+5 → no further ticks. After releasing both, a new up press gives one `tick_up`=6'b001000.
5. Seven mode presses → `field_sel` steps 0,1,2,3,4,5, then `adjust_en`=0 with `field_sel`=0. An up press now gives no tick.
6. `rst` pulsed at t0+12 during up auto-repeat → outputs 0 immediately, `adjust_en`=0. Up kept held after reset → no tick.

Source files
------------

// File: rtl/clock_adjust_pkg.sv
// Shared types and constants for the clock/calendar manual-adjust front-end.
package clock_adjust_pkg;

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_DELAY  = 2'd1,
    R_REPEAT = 2'd2,
    R_LOCK   = 2'd3
  } rep_state_e;

  localparam int unsigned FIELD_SEC   = 0;
  localparam int unsigned FIELD_MIN   = 1;
  localparam int unsigned FIELD_HOUR  = 2;
  localparam int unsigned FIELD_DAY   = 3;
  localparam int unsigned FIELD_MONTH = 4;
  localparam int unsigned FIELD_YEAR  = 5;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser, stable-count debouncer and registered rising-edge
// pulse for one raw push-button.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;

  // The counter only runs while the synchronised level disagrees with the
  // debounced level, so any agreeing cycle restarts the stability window.
  always_comb begin
    sync_d  = {sync_q[0], btn_raw};
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    rise_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/adjust_tick_generator.sv
// Turns mode/up/down buttons into per-field tick_up/tick_down pulses with
// field cycling and press-and-hold auto-repeat.
module adjust_tick_generator
  import clock_adjust_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 20,
  parameter int unsigned REPEAT_DELAY    = 500,
  parameter int unsigned REPEAT_PERIOD   = 100,
  parameter int unsigned NUM_FIELDS      = 6,
  parameter int unsigned FIELD_BITS      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_mode,
  input  logic                  btn_up,
  input  logic                  btn_down,
  output logic                  adjust_en,
  output logic [FIELD_BITS-1:0] field_sel,
  output logic [NUM_FIELDS-1:0] tick_up,
  output logic [NUM_FIELDS-1:0] tick_down
);

  localparam int unsigned TW = $clog2(REPEAT_DELAY + 1);

  logic mode_lvl_unused, mode_rise;
  logic up_lvl, up_rise;
  logic dn_lvl, dn_rise;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk(clk), .rst(rst), .btn_raw(btn_mode), .level(mode_lvl_unused), .rise(mode_rise)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(clk), .rst(rst), .btn_raw(btn_up), .level(up_lvl), .rise(up_rise)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk(clk), .rst(rst), .btn_raw(btn_down), .level(dn_lvl), .rise(dn_rise)
  );

  rep_state_e            rep_state_q, rep_state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  dir_up_q, dir_up_d;
  logic                  adjust_en_q, adjust_en_d;
  logic [FIELD_BITS-1:0] field_sel_q, field_sel_d;
  logic [NUM_FIELDS-1:0] tick_up_q, tick_up_d;
  logic [NUM_FIELDS-1:0] tick_down_q, tick_down_d;
  logic                  fire_up, fire_dn, lock_cond, act_lvl;

  // Mode register: IDLE -> field 0 -> ... -> last field -> IDLE.
  always_comb begin
    adjust_en_d = adjust_en_q;
    field_sel_d = field_sel_q;
    if (mode_rise) begin
      if (!adjust_en_q) begin
        adjust_en_d = 1'b1;
        field_sel_d = FIELD_BITS'(FIELD_SEC);
      end else if (field_sel_q == FIELD_BITS'(NUM_FIELDS - 1)) begin
        adjust_en_d = 1'b0;
        field_sel_d = '0;
      end else begin
        field_sel_d = field_sel_q + FIELD_BITS'(1);
      end
    end
  end

  // Repeat FSM. A mode edge always lands the next cycle with adjust_en
  // changed, so treating it as a lock condition covers adjust_en falling too.
  always_comb begin
    rep_state_d = rep_state_q;
    timer_d     = timer_q;
    dir_up_d    = dir_up_q;
    fire_up     = 1'b0;
    fire_dn     = 1'b0;
    lock_cond   = (up_lvl & dn_lvl) | mode_rise | ~adjust_en_q;
    act_lvl     = dir_up_q ? up_lvl : dn_lvl;
    case (rep_state_q)
      R_IDLE: begin
        if (up_rise && dn_rise) begin
          rep_state_d = R_LOCK;
        end else if (adjust_en_q && !mode_rise) begin
          if (up_rise && !dn_lvl) begin
            fire_up     = 1'b1;
            dir_up_d    = 1'b1;
            timer_d     = TW'(REPEAT_DELAY);
            rep_state_d = R_DELAY;
          end else if (dn_rise && !up_lvl) begin
            fire_dn     = 1'b1;
            dir_up_d    = 1'b0;
            timer_d     = TW'(REPEAT_DELAY);
            rep_state_d = R_DELAY;
          end
        end
      end
      R_DELAY, R_REPEAT: begin
        if (lock_cond) begin
          rep_state_d = R_LOCK;
        end else if (!act_lvl) begin
          rep_state_d = R_IDLE;
        end else if (timer_q == TW'(1)) begin
          fire_up     = dir_up_q;
          fire_dn     = ~dir_up_q;
          timer_d     = TW'(REPEAT_PERIOD);
          rep_state_d = R_REPEAT;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      R_LOCK: begin
        if (!up_lvl && !dn_lvl) begin
          rep_state_d = R_IDLE;
        end
      end
      default: rep_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    tick_up_d   = fire_up ? (NUM_FIELDS'(1) << field_sel_q) : '0;
    tick_down_d = fire_dn ? (NUM_FIELDS'(1) << field_sel_q) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_state_q <= R_IDLE;
      timer_q     <= '0;
      dir_up_q    <= 1'b0;
      adjust_en_q <= 1'b0;
      field_sel_q <= '0;
      tick_up_q   <= '0;
      tick_down_q <= '0;
    end else begin
      rep_state_q <= rep_state_d;
      timer_q     <= timer_d;
      dir_up_q    <= dir_up_d;
      adjust_en_q <= adjust_en_d;
      field_sel_q <= field_sel_d;
      tick_up_q   <= tick_up_d;
      tick_down_q <= tick_down_d;
    end
  end

  assign adjust_en = adjust_en_q;
  assign field_sel = field_sel_q;
  assign tick_up   = tick_up_q;
  assign tick_down = tick_down_q;

endmodule

// File: tb/tb_adjust_tick_generator.sv
// Bench for adjust_tick_generator: directed test-plan scenarios plus random
// button traffic, compared every cycle against a timing-rule reference model.
module tb_adjust_tick_generator;

  localparam int DC = 4;
  localparam int RD = 10;
  localparam int RP = 3;
  localparam int NF = 6;
  localparam int FB = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          btn_mode, btn_up, btn_down;
  logic          adjust_en;
  logic [FB-1:0] field_sel;
  logic [NF-1:0] tick_up, tick_down;

  always #5 clk = ~clk;

  adjust_tick_generator #(
    .DEBOUNCE_CYCLES(DC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
    .NUM_FIELDS(NF), .FIELD_BITS(FB)
  ) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .adjust_en(adjust_en), .field_sel(field_sel), .tick_up(tick_up), .tick_down(tick_down)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cnt_up = 0;
  int cnt_dn = 0;

  // Reference model: raw sample history per button (0 mode, 1 up, 2 down),
  // debounced levels from a sliding window, mode as 0 (idle) or field+1,
  // press tracking as idle/active/locked with tick times from elapsed time.
  bit            hist [3][8192];
  int            n_edge;
  bit            lvl  [3];
  bit            rise [3];
  int            mode_st;
  int            rp_st;
  bit            rp_up;
  int            t0;
  logic [NF-1:0] exp_tu, exp_td;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit sample(int b, int k);
    return (k < 0) ? 1'b0 : hist[b][k];
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 8192; k++) hist[b][k] = 1'b0;
      lvl[b]  = 1'b0;
      rise[b] = 1'b0;
    end
    n_edge  = 0;
    mode_st = 0;
    rp_st   = 0;
    rp_up   = 1'b0;
    t0      = 0;
    exp_tu  = '0;
    exp_td  = '0;
  endtask

  task automatic model_step(input bit m, input bit u, input bit d);
    bit adj, fire, all_diff;
    int fld, el;
    hist[0][n_edge] = m;
    hist[1][n_edge] = u;
    hist[2][n_edge] = d;
    adj  = (mode_st != 0);
    fld  = adj ? mode_st - 1 : 0;
    fire = 1'b0;
    el   = n_edge - t0;
    case (rp_st)
      0: begin
        if (rise[1] && rise[2]) rp_st = 2;
        else if (adj && !rise[0]) begin
          if (rise[1] && !lvl[2]) begin
            fire = 1'b1; rp_up = 1'b1; rp_st = 1; t0 = n_edge;
          end else if (rise[2] && !lvl[1]) begin
            fire = 1'b1; rp_up = 1'b0; rp_st = 1; t0 = n_edge;
          end
        end
      end
      1: begin
        if ((lvl[1] && lvl[2]) || rise[0] || !adj) rp_st = 2;
        else if (!(rp_up ? lvl[1] : lvl[2])) rp_st = 0;
        else if (el == RD || (el > RD && (el - RD) % RP == 0)) fire = 1'b1;
      end
      default: begin
        if (!lvl[1] && !lvl[2]) rp_st = 0;
      end
    endcase
    exp_tu = (fire && rp_up)  ? (NF'(1) << fld) : '0;
    exp_td = (fire && !rp_up) ? (NF'(1) << fld) : '0;
    if (rise[0]) mode_st = (mode_st == NF) ? 0 : mode_st + 1;
    // Level flips once the last DC synchronised samples all disagree with it.
    for (int b = 0; b < 3; b++) begin
      all_diff = 1'b1;
      for (int k = n_edge - DC - 1; k <= n_edge - 2; k++)
        if (sample(b, k) == lvl[b]) all_diff = 1'b0;
      rise[b] = 1'b0;
      if (all_diff) begin
        lvl[b]  = ~lvl[b];
        rise[b] = lvl[b];
      end
    end
    n_edge++;
  endtask

  task automatic cyc(input bit m, input bit u, input bit d);
    btn_mode = m;
    btn_up   = u;
    btn_down = d;
    @(posedge clk);
    #1;
    model_step(m, u, d);
    if (tick_up != '0) cnt_up++;
    if (tick_down != '0) cnt_dn++;
    check("tick_up",   32'(tick_up),   32'(exp_tu));
    check("tick_down", 32'(tick_down), 32'(exp_td));
    check("adjust_en", 32'(adjust_en), 32'(mode_st != 0));
    check("field_sel", 32'(field_sel), 32'((mode_st == 0) ? 0 : mode_st - 1));
  endtask

  task automatic hold(input bit m, input bit u, input bit d, input int n);
    for (int i = 0; i < n; i++) cyc(m, u, d);
  endtask

  task automatic press_mode();
    hold(1'b1, 1'b0, 1'b0, 6);
    hold(1'b0, 1'b0, 1'b0, 6);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    #1;
    check("rst_adjust_en", 32'(adjust_en), 32'd0);
    check("rst_field_sel", 32'(field_sel), 32'd0);
    check("rst_tick_up",   32'(tick_up),   32'd0);
    check("rst_tick_down", 32'(tick_down), 32'd0);
    model_reset();
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int r, len;
    rst = 1'b1; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    do_reset(2);

    // 1: field 2, single short up press
    press_mode(); press_mode(); press_mode();
    cnt_up = 0;
    hold(1'b0, 1'b1, 1'b0, 8);
    hold(1'b0, 1'b0, 1'b0, 10);
    check("s1_tick_count", 32'(cnt_up), 32'd1);

    // 2: field 0, long up hold with auto-repeat
    do_reset(2);
    press_mode();
    hold(1'b0, 1'b1, 1'b0, 36);
    hold(1'b0, 1'b0, 1'b0, 20);

    // 3: field 1, bouncing down button
    press_mode();
    cnt_dn = 0;
    for (int i = 0; i < 5; i++) begin
      hold(1'b0, 1'b0, 1'b1, 2);
      hold(1'b0, 1'b0, 1'b0, 2);
    end
    hold(1'b0, 1'b0, 1'b0, 10);
    check("s3_no_tick_down", 32'(cnt_dn), 32'd0);
    check("s3_field_sel", 32'(field_sel), 32'd1);

    // 4: field 3, down joins a held up -> lock, then fresh up press
    press_mode(); press_mode();
    cnt_up = 0;
    hold(1'b0, 1'b1, 1'b0, 5);
    hold(1'b0, 1'b1, 1'b1, 30);
    hold(1'b0, 1'b0, 1'b0, 10);
    check("s4_lock_ticks", 32'(cnt_up), 32'd1);
    cnt_up = 0;
    hold(1'b0, 1'b1, 1'b0, 8);
    hold(1'b0, 1'b0, 1'b0, 10);
    check("s4_fresh_press", 32'(cnt_up), 32'd1);

    // 5: full mode cycle back to idle, then up ignored
    do_reset(2);
    for (int k = 0; k < 6; k++) begin
      press_mode();
      check("s5_field_step", 32'(field_sel), 32'(k));
    end
    press_mode();
    check("s5_idle_adjust_en", 32'(adjust_en), 32'd0);
    check("s5_idle_field_sel", 32'(field_sel), 32'd0);
    cnt_up = 0;
    hold(1'b0, 1'b1, 1'b0, 10);
    hold(1'b0, 1'b0, 1'b0, 10);
    check("s5_no_tick", 32'(cnt_up), 32'd0);

    // 6: reset during auto-repeat with up still held
    press_mode();
    hold(1'b0, 1'b1, 1'b0, 18);
    do_reset(3);
    cnt_up = 0;
    hold(1'b0, 1'b1, 1'b0, 30);
    check("s6_no_tick_after_rst", 32'(cnt_up), 32'd0);
    hold(1'b0, 1'b0, 1'b0, 10);

    // Random traffic
    do_reset(2);
    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: begin
          hold(1'b1, 1'b0, 1'b0, $urandom_range(1, 8));
          hold(1'b0, 1'b0, 1'b0, $urandom_range(1, 8));
        end
        3, 4: begin
          hold(1'b0, 1'b1, 1'b0, $urandom_range(1, 40));
          hold(1'b0, 1'b0, 1'b0, $urandom_range(1, 12));
        end
        5, 6: begin
          hold(1'b0, 1'b0, 1'b1, $urandom_range(1, 40));
          hold(1'b0, 1'b0, 1'b0, $urandom_range(1, 12));
        end
        7: begin
          len = $urandom_range(5, 20);
          hold(1'b0, 1'b1, 1'b0, len);
          hold(1'b0, 1'b1, 1'b1, $urandom_range(1, 15));
          hold(1'b0, 1'b0, 1'b1, $urandom_range(1, 15));
          hold(1'b0, 1'b0, 1'b0, $urandom_range(6, 12));
        end
        8: begin
          for (int i = 0; i < 12; i++)
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
          hold(1'b0, 1'b0, 1'b0, 8);
        end
        default: begin
          hold(1'b0, 1'b1, 1'b1, $urandom_range(1, 10));
          hold(1'b0, 1'b0, 1'b0, $urandom_range(1, 10));
        end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
